serial_logic_engine: RTL and testbench

Parametrised bit-serial logic processor, the successor to the fixed 8-bit lab processor.
- Holds two WIDTH-bit registers A and B.
- On Execute, applies a run-time-selected bitwise function F to A and B, one bit per clock.
- Routes each result bit back into A and/or B under run-time route select R.
- Sits between the input synchronizers and the hex-display drivers in the top level, and adds Busy/Done status.

---
 rtl/serial_logic_pkg.sv | 43 ++++
 rtl/serial_logic_engine_if.sv | 29 ++
 rtl/serial_logic_bit.sv | 37 +++
 rtl/serial_logic_engine.sv | 124 ++++++++++++
 tb/tb_serial_logic_engine.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/serial_logic_pkg.sv
// Shared types and the bitwise function helper for the bit-serial logic engine.
package serial_logic_pkg;

  typedef enum logic [2:0] {
    FN_AND  = 3'b000,
    FN_OR   = 3'b001,
    FN_XOR  = 3'b010,
    FN_ONE  = 3'b011,
    FN_NAND = 3'b100,
    FN_NOR  = 3'b101,
    FN_XNOR = 3'b110,
    FN_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    RT_KEEP = 2'b00,
    RT_TO_B = 2'b01,
    RT_TO_A = 2'b10,
    RT_SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  function automatic logic apply_func(func_e f, logic x, logic y);
    logic r;
    case (f)
      FN_AND:  r = x & y;
      FN_OR:   r = x | y;
      FN_XOR:  r = x ^ y;
      FN_ONE:  r = 1'b1;
      FN_NAND: r = ~(x & y);
      FN_NOR:  r = ~(x | y);
      FN_XNOR: r = ~(x ^ y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_logic_engine_if.sv
// Control/data bundle between the synchronizers, the engine and the hex drivers.
// OpCount exists only when SERIAL_LOGIC_OPCOUNT_EN is defined.
interface serial_logic_engine_if #(parameter int WIDTH = 8);

  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [2:0]       F;
  logic [1:0]       R;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
`ifdef SERIAL_LOGIC_OPCOUNT_EN
  logic [15:0]      OpCount;

  modport master (output LoadA, LoadB, Execute, Din, F, R,
                  input  A, B, Busy, Done, OpCount);
  modport slave  (input  LoadA, LoadB, Execute, Din, F, R,
                  output A, B, Busy, Done, OpCount);
`else
  modport master (output LoadA, LoadB, Execute, Din, F, R,
                  input  A, B, Busy, Done);
  modport slave  (input  LoadA, LoadB, Execute, Din, F, R,
                  output A, B, Busy, Done);
`endif

endinterface

// File: rtl/serial_logic_bit.sv
// One-bit datapath slice: evaluates the selected function on the LSBs and
// picks the bits that re-enter the MSBs of A and B.
module serial_logic_bit
  import serial_logic_pkg::*;
(
  input  func_e  f_i,
  input  route_e r_i,
  input  logic   a0_i,
  input  logic   b0_i,
  output logic   new_a_o,
  output logic   new_b_o,
  output logic   fb_o
);

  always_comb begin
    fb_o    = apply_func(f_i, a0_i, b0_i);
    new_a_o = a0_i;
    new_b_o = b0_i;
    case (r_i)
      RT_KEEP: begin
        new_a_o = a0_i;
        new_b_o = b0_i;
      end
      RT_TO_B: new_b_o = fb_o;
      RT_TO_A: new_a_o = fb_o;
      RT_SWAP: begin
        new_a_o = b0_i;
        new_b_o = a0_i;
      end
      default: begin
        new_a_o = a0_i;
        new_b_o = b0_i;
      end
    endcase
  end

endmodule

// File: rtl/serial_logic_engine.sv
// Bit-serial logic processor: WIDTH shift cycles per operation, Busy/Done status.
// Defining SERIAL_LOGIC_OPCOUNT_EN adds a 16-bit completed-operation counter.
module serial_logic_engine
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic                  Clk,
  input  logic                  Reset,
  serial_logic_engine_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  func_e            f_q, f_d;
  route_e           r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             new_a_s, new_b_s, fb_s;

  serial_logic_bit u_bit (
    .f_i     (f_q),
    .r_i     (r_q),
    .a0_i    (a_q[0]),
    .b0_i    (b_q[0]),
    .new_a_o (new_a_s),
    .new_b_o (new_b_s),
    .fb_o    (fb_s)
  );

  // Next-state, datapath and status decode; loads win over Execute in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.LoadA) a_d = bus.Din;
        else           a_d = a_q;
        if (bus.LoadB) b_d = bus.Din;
        else           b_d = b_q;
        if (bus.Execute) begin
          f_d     = func_e'(bus.F);
          r_d     = route_e'(bus.R);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d = {new_a_s, a_q[WIDTH-1:1]};
        b_d = {new_b_s, b_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!bus.Execute) state_d = ST_IDLE;
        else              state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f_q     <= FN_AND;
      r_q     <= RT_KEEP;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

`ifdef SERIAL_LOGIC_OPCOUNT_EN
  logic [15:0] opcount_q, opcount_d;

  always_comb begin
    if (done_d) opcount_d = opcount_q + 16'd1;
    else        opcount_d = opcount_q;
  end

  // Completed-operation counter, wraps naturally at 16 bits
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) opcount_q <= 16'd0;
    else        opcount_q <= opcount_d;
  end

  assign bus.OpCount = opcount_q;
`endif

endmodule

// File: tb/tb_serial_logic_engine.sv
// Directed bench for serial_logic_engine at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_serial_logic_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  serial_logic_engine_if #(.WIDTH(8))  b8 ();
  serial_logic_engine_if #(.WIDTH(16)) b16 ();

  serial_logic_engine #(.WIDTH(8))  dut8  (.Clk(clk), .Reset(rst_n), .bus(b8.slave));
  serial_logic_engine #(.WIDTH(16)) dut16 (.Clk(clk), .Reset(rst_n), .bus(b16.slave));

  // Whole-word reference: serial application over WIDTH bits equals the bitwise result
  function automatic logic [31:0] model(logic [2:0] f, logic [1:0] r,
                                        logic [15:0] a, logic [15:0] b, int w);
    logic [15:0] fv, m, na, nb;
    m = 16'hFFFF >> (16 - w);
    case (f)
      3'd0: fv = a & b;
      3'd1: fv = a | b;
      3'd2: fv = a ^ b;
      3'd3: fv = 16'hFFFF;
      3'd4: fv = ~(a & b);
      3'd5: fv = ~(a | b);
      3'd6: fv = ~(a ^ b);
      default: fv = 16'h0000;
    endcase
    case (r)
      2'd0: begin na = a;  nb = b;  end
      2'd1: begin na = a;  nb = fv; end
      2'd2: begin na = fv; nb = b;  end
      default: begin na = b; nb = a; end
    endcase
    return {na & m, nb & m};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load8(logic [7:0] a, logic [7:0] b);
    @(negedge clk); b8.Din = a; b8.LoadA = 1'b1;
    @(negedge clk); b8.LoadA = 1'b0; b8.Din = b; b8.LoadB = 1'b1;
    @(negedge clk); b8.LoadB = 1'b0;
    check("load_a", {24'h0, b8.A}, {24'h0, a});
    check("load_b", {24'h0, b8.B}, {24'h0, b});
  endtask

  // One operation on the 8-bit engine; disturb>0 injects a load/F/R change in that SHIFT cycle,
  // hold keeps Execute high, same loads A together with Execute.
  task automatic op8(string tag, logic [7:0] a, logic [7:0] b, logic [2:0] f, logic [1:0] r,
                     int disturb, bit hold, bit same);
    int n = 0, busy_n = 0, done_n = 0;
    if (same) load8(8'h00, b);
    else      load8(a, b);
    exp_q.push_back(model(f, r, {8'h00, a}, {8'h00, b}, 8));
    @(negedge clk);
    b8.F = f; b8.R = r; b8.Execute = 1'b1;
    if (same) begin b8.Din = a; b8.LoadA = 1'b1; end
    while (done_n == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (!hold) b8.Execute = 1'b0;
      if (n == disturb) begin
        b8.LoadA = 1'b1; b8.Din = 8'hEE; b8.F = ~f; b8.R = ~r;
      end else begin
        b8.LoadA = 1'b0;
      end
      if (b8.Busy) busy_n++;
      if (b8.Done) done_n++;
    end
    check({tag, "_done"}, done_n, 1);
    check({tag, "_latency"}, n, 9);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_result"}, {8'h00, b8.A, 8'h00, b8.B}, exp_q.pop_front());
    if (hold) begin
      repeat (21) begin
        @(negedge clk);
        if (b8.Done) done_n++;
        if (b8.Busy) busy_n++;
      end
      check({tag, "_hold_one_done"}, done_n, 1);
      check({tag, "_hold_no_rerun"}, busy_n, 8);
      check({tag, "_hold_a"}, {24'h0, b8.A}, {24'h0, a});
      b8.Execute = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'h0, b8.Done}, 32'h0);
  endtask

  initial begin
    int n, busy_n, done_n;
    rst_n = 1'b0;
    b8.LoadA = 1'b0;  b8.LoadB = 1'b0;  b8.Execute = 1'b0;  b8.Din = 8'h00;  b8.F = 3'b000;  b8.R = 2'b00;
    b16.LoadA = 1'b0; b16.LoadB = 1'b0; b16.Execute = 1'b0; b16.Din = 16'h0000; b16.F = 3'b000; b16.R = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_ab", {8'h00, b8.A, 8'h00, b8.B}, 32'h0);
    check("reset_status", {30'h0, b8.Busy, b8.Done}, 32'h0);
    rst_n = 1'b1;

    op8("xor_to_a", 8'h33, 8'h55, 3'b010, 2'b10, -1, 1'b0, 1'b0);
    op8("swap",     8'hA5, 8'h3C, 3'b000, 2'b11, -1, 1'b0, 1'b0);
    op8("keep",     8'hA5, 8'h3C, 3'b010, 2'b00, -1, 1'b0, 1'b0);
    op8("hold_xnor", 8'h0F, 8'hFF, 3'b110, 2'b10, -1, 1'b1, 1'b0);
    op8("disturb",  8'h33, 8'h55, 3'b010, 2'b10, 3, 1'b0, 1'b0);
    op8("nand_to_b", 8'hC3, 8'h5A, 3'b100, 2'b01, -1, 1'b0, 1'b0);
    op8("one_to_b", 8'h12, 8'h34, 3'b011, 2'b01, -1, 1'b0, 1'b0);
    op8("zero_to_a", 8'hFE, 8'h01, 3'b111, 2'b10, -1, 1'b0, 1'b0);
    op8("or_to_a",  8'h81, 8'h18, 3'b001, 2'b10, -1, 1'b0, 1'b0);
    op8("and_to_b", 8'hF0, 8'h3C, 3'b000, 2'b01, -1, 1'b0, 1'b0);
    op8("nor_to_b", 8'h0C, 8'h30, 3'b101, 2'b01, -1, 1'b0, 1'b0);
    op8("load_with_exec", 8'hF0, 8'h3C, 3'b000, 2'b10, -1, 1'b0, 1'b1);

    // Asynchronous reset in the fourth SHIFT cycle
    load8(8'hA5, 8'h3C);
    @(negedge clk); b8.F = 3'b010; b8.R = 2'b10; b8.Execute = 1'b1;
    @(negedge clk); b8.Execute = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", {31'h0, b8.Busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ab", {8'h00, b8.A, 8'h00, b8.B}, 32'h0);
    check("rst_mid_status", {30'h0, b8.Busy, b8.Done}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    op8("after_reset", 8'h12, 8'h34, 3'b010, 2'b01, -1, 1'b0, 1'b0);

    // 16-bit instance
    @(negedge clk); b16.Din = 16'h00FF; b16.LoadA = 1'b1;
    @(negedge clk); b16.LoadA = 1'b0; b16.Din = 16'h0F0F; b16.LoadB = 1'b1;
    @(negedge clk); b16.LoadB = 1'b0; b16.F = 3'b101; b16.R = 2'b01; b16.Execute = 1'b1;
    exp_q.push_back(model(3'b101, 2'b01, 16'h00FF, 16'h0F0F, 16));
    n = 0; busy_n = 0; done_n = 0;
    while (done_n == 0 && n < 60) begin
      @(negedge clk);
      n++;
      b16.Execute = 1'b0;
      if (b16.Busy) busy_n++;
      if (b16.Done) done_n++;
    end
    check("w16_done", done_n, 1);
    check("w16_latency", n, 17);
    check("w16_busy_cycles", busy_n, 16);
    check("w16_result", {b16.A, b16.B}, exp_q.pop_front());
    @(negedge clk);
    check("w16_done_pulse", {31'h0, b16.Done}, 32'h0);
`ifdef SERIAL_LOGIC_OPCOUNT_EN
    check("w16_opcount", {16'h0, b16.OpCount}, 32'd1);
    check("w8_opcount_since_reset", {16'h0, b8.OpCount}, 32'd1);
`endif
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
